// File: rtl/biquad8_pkg.sv
// Shared types and constants for the biquad8 coefficient loader: FSM states,
// biquad control-space addresses and the packed table-entry layout.
package biquad8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_XFER,
    ST_NEXT,
    ST_UPD,
    ST_DONE
  } state_t;

  localparam logic [6:0]  ADDR_UPDATE       = 7'h00;
  localparam logic [6:0]  ADDR_FIR          = 7'h04;
  localparam logic [6:0]  ADDR_IIR          = 7'h08;
  localparam logic [6:0]  ADDR_POLEFIR_BASE = 7'h10;
  localparam logic [31:0] UPDATE_DAT        = 32'h1;

  // Entry layout {adr[6:0], coefficient[17:0]}; the biquad is word-addressed.
  localparam int         ENTRY_W  = 25;
  localparam logic [6:0] ADR_MASK = 7'h7C;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [6:0] adr,
                                                    input logic [17:0] dat);
    return {adr & ADR_MASK, dat};
  endfunction

endpackage

// File: rtl/biquad8_coeff_loader_if.sv
// Wishbone master port between the coefficient loader and the biquad8 control port.
interface biquad8_coeff_loader_if;
  // Classic single write: cyc=stb=we held with stable adr/dat/sel until the
  // target answers with one cycle of ack (done) or err (failed); err has priority.
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [6:0]  wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    input  wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
    output wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/biquad8_coeff_table.sv
// Coefficient table RAM: one write port, one registered read port, no reset.
module biquad8_coeff_table #(
  parameter int DEPTH = 32,
  parameter int W     = 25
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (rd_en) rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/biquad8_coeff_loader.sv
// Replays a host-loaded (address, coefficient) table as single Wishbone writes
// into the biquad8 control space, optionally followed by an update write.
module biquad8_coeff_loader
  import biquad8_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int TIMEOUT   = 255,
  parameter int DO_UPDATE = 1
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     tbl_wr_i,
  input  logic [$clog2(DEPTH)-1:0] tbl_idx_i,
  input  logic [6:0]               tbl_adr_i,
  input  logic [17:0]              tbl_dat_i,
  input  logic [$clog2(DEPTH):0]   len_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  biquad8_coeff_loader_if.master   wbm,
  output state_t                   dbg_state
);

  localparam int              IW       = $clog2(DEPTH);
  localparam logic [IW-1:0]   IDX_ONE  = 1;
  localparam logic [IW:0]     REM_ONE  = 1;
  localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);

  state_t             state;
  logic [IW-1:0]      idx;
  logic [IW:0]        rem;
  logic [15:0]        tcnt;
  logic               cyc_q;
  logic               upd_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [ENTRY_W-1:0] rd_q;
  logic               tbl_we;
  logic               rd_en;

  // Host writes land only in IDLE, so a write issued with start is seen by FETCH.
  assign tbl_we = tbl_wr_i && (state == ST_IDLE);
  assign rd_en  = (state == ST_FETCH);

  biquad8_coeff_table #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_table (
    .clk     (wb_clk_i),
    .wr_en   (tbl_we),
    .wr_idx  (tbl_idx_i),
    .wr_data (make_entry(tbl_adr_i, tbl_dat_i)),
    .rd_en   (rd_en),
    .rd_idx  (idx),
    .rd_data (rd_q)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state  <= ST_IDLE;
      idx    <= '0;
      rem    <= '0;
      tcnt   <= '0;
      cyc_q  <= 1'b0;
      upd_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            rem    <= len_i;
            idx    <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            if (len_i != '0) begin
              state <= ST_FETCH;
            end else if (DO_UPDATE != 0) begin
              state <= ST_UPD;
              cyc_q <= 1'b1;
              upd_q <= 1'b1;
              tcnt  <= '0;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_FETCH: begin
          state <= ST_XFER;
          cyc_q <= 1'b1;
          upd_q <= 1'b0;
          tcnt  <= '0;
        end
        ST_XFER, ST_UPD: begin
          // An ack on the last allowed cycle still completes the write.
          if (wbm.wbm_err_i || (!wbm.wbm_ack_i && tcnt == TMO_LAST)) begin
            cyc_q <= 1'b0;
            upd_q <= 1'b0;
            err_q <= 1'b1;
            state <= ST_DONE;
          end else if (wbm.wbm_ack_i) begin
            cyc_q <= 1'b0;
            upd_q <= 1'b0;
            state <= (state == ST_XFER) ? ST_NEXT : ST_DONE;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 16'd1;
          end
        end
        ST_NEXT: begin
          idx <= idx + IDX_ONE;
          rem <= rem - REM_ONE;
          if (rem != REM_ONE) begin
            state <= ST_FETCH;
          end else if (DO_UPDATE != 0) begin
            state <= ST_UPD;
            cyc_q <= 1'b1;
            upd_q <= 1'b1;
            tcnt  <= '0;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The RAM read register is the data-phase register; cyc gating keeps the bus at 0 when idle.
  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = cyc_q;
  assign wbm.wbm_adr_o = !cyc_q ? 7'h00 : (upd_q ? ADDR_UPDATE : rd_q[24:18]);
  assign wbm.wbm_dat_o = !cyc_q ? 32'h0 : (upd_q ? UPDATE_DAT : {14'b0, rd_q[17:0]});
  assign wbm.wbm_sel_o = !cyc_q ? 4'h0 : (upd_q ? 4'h1 : 4'hF);

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Randomized bench for biquad8_coeff_loader: a Wishbone slave model with
// programmable latency/error/hang, and a table model that predicts every write.
module tb_biquad8_coeff_loader;
  import biquad8_pkg::*;

  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 255;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i;
  logic        tbl_wr_i;
  logic [4:0]  tbl_idx_i;
  logic [6:0]  tbl_adr_i;
  logic [17:0] tbl_dat_i;
  logic [5:0]  len_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  state_t      dbg_state;

  biquad8_coeff_loader_if bus ();

  biquad8_coeff_loader #(
    .DEPTH     (DEPTH),
    .TIMEOUT   (TIMEOUT),
    .DO_UPDATE (1)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .tbl_wr_i   (tbl_wr_i),
    .tbl_idx_i  (tbl_idx_i),
    .tbl_adr_i  (tbl_adr_i),
    .tbl_dat_i  (tbl_dat_i),
    .len_i      (len_i),
    .start_i    (start_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .wbm        (bus),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  int edge_cnt = 0;
  always @(posedge wb_clk_i) edge_cnt <= edge_cnt + 1;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [44:0] exp_q[$];
  logic [6:0]  ref_adr [DEPTH];
  logic [17:0] ref_dat [DEPTH];

  int cfg_lat    = 1;
  int cfg_err_at = -1;
  bit cfg_hang   = 0;
  int wr_no      = 0;
  bit first_in_burst = 0;
  int start_edge = 0;
  int fall_edge  = 0;
  int done_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [44:0] exp_wr(input logic [6:0] adr, input logic [31:0] dat,
                                         input logic [3:0] sel);
    return {2'b11, adr, dat, sel};
  endfunction

  function automatic logic [44:0] exp_tbl(input int i);
    return exp_wr(ref_adr[i] & 7'h7C, {14'b0, ref_dat[i]}, 4'hF);
  endfunction

  // ---------------- Wishbone slave model / bus monitor ----------------
  initial begin
    bit          prev = 0;
    int          hold = 0;
    int          low_cnt = 0;
    int          cur_lat = 1;
    bit          stable = 1;
    logic [44:0] cur;
    logic [44:0] wr_cur = '0;
    logic [44:0] e;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_err_i = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      bus.wbm_ack_i = 1'b0;
      bus.wbm_err_i = 1'b0;
      if (!wb_rst_n_i) begin
        prev = 0;
        continue;
      end
      if (done_o) begin
        done_cnt++;
        check("done_lag", edge_cnt - fall_edge, 1);
      end
      cur = {bus.wbm_we_o, bus.wbm_stb_o, bus.wbm_adr_o, bus.wbm_dat_o, bus.wbm_sel_o};
      if (bus.wbm_cyc_o) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            e = '0;
            check("wr_extra", cur, e);
          end else begin
            e = exp_q.pop_front();
            check("wr", cur, e);
          end
          // Update write follows NEXT directly; table writes also pass through FETCH.
          if (first_in_burst) check("first_rise", edge_cnt - start_edge, (e[3:0] == 4'h1) ? 1 : 2);
          else                check("gap", low_cnt, (e[3:0] == 4'h1) ? 1 : 2);
          first_in_burst = 0;
          hold    = 0;
          stable  = 1;
          wr_cur  = cur;
          cur_lat = (cfg_lat == 0) ? int'($urandom_range(1, 10)) : cfg_lat;
        end
        hold++;
        if (cur !== wr_cur) stable = 0;
        if (!cfg_hang && hold == cur_lat) begin
          if (wr_no == cfg_err_at) bus.wbm_err_i = 1'b1;
          else                     bus.wbm_ack_i = 1'b1;
        end
      end else begin
        if (prev) begin
          check("stable", stable, 1);
          check(cfg_hang ? "timeout_hold" : "hold", hold, cfg_hang ? TIMEOUT : cur_lat);
          wr_no++;
          fall_edge = edge_cnt;
          low_cnt   = 0;
        end
        low_cnt++;
      end
      prev = bus.wbm_cyc_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_entry(input int idx, input logic [6:0] adr, input logic [17:0] dat);
    @(negedge wb_clk_i);
    tbl_wr_i  = 1'b1;
    tbl_idx_i = 5'(idx);
    tbl_adr_i = adr;
    tbl_dat_i = dat;
    ref_adr[idx] = adr;
    ref_dat[idx] = dat;
    @(negedge wb_clk_i);
    tbl_wr_i = 1'b0;
  endtask

  task automatic do_burst(input int len, input int lat, input int err_at, input bit hang,
                          input bit poke, input bit wr_start);
    bit         exp_abort = 0;
    int         n = 0;
    int         d0;
    logic [6:0] wa = 7'($urandom_range(0, 127));
    logic [17:0] wd = 18'($urandom_range(0, 262143));
    if (wr_start) begin
      ref_adr[0] = wa;
      ref_dat[0] = wd;
    end
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(exp_tbl(i));
      if (hang || i == err_at) begin
        exp_abort = 1;
        break;
      end
    end
    if (!exp_abort) exp_q.push_back(exp_wr(ADDR_UPDATE, UPDATE_DAT, 4'h1));
    cfg_lat = lat; cfg_err_at = err_at; cfg_hang = hang; wr_no = 0;
    @(negedge wb_clk_i);
    first_in_burst = 1;
    start_edge = edge_cnt;
    d0 = done_cnt;
    len_i   = 6'(len);
    start_i = 1'b1;
    if (wr_start) begin
      tbl_wr_i = 1'b1; tbl_idx_i = '0; tbl_adr_i = wa; tbl_dat_i = wd;
    end
    while (done_cnt == d0 && n < 4000) begin
      @(negedge wb_clk_i);
      n++;
      if (n == 1) begin
        start_i = 1'b0;
        tbl_wr_i = 1'b0;
        check("busy_hi", busy_o, 1);
        check("err_clr", err_o, 0);
      end
      if (poke && n == 4) begin
        start_i = 1'b1; len_i = 6'd1;
        tbl_wr_i = 1'b1; tbl_idx_i = '0; tbl_adr_i = ~ref_adr[0]; tbl_dat_i = ~ref_dat[0];
      end
      if (poke && n == 5) begin
        start_i = 1'b0; tbl_wr_i = 1'b0;
      end
    end
    check("done_seen", done_cnt - d0, 1);
    @(negedge wb_clk_i);
    check("busy_lo", busy_o, 0);
    check("done_once", done_cnt - d0, 1);
    check("err", err_o, exp_abort);
    check("q_empty", exp_q.size(), 0);
    check("state_idle", dbg_state, ST_IDLE);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int d0;
    wb_rst_n_i = 1'b0;
    tbl_wr_i = 1'b0; tbl_idx_i = '0; tbl_adr_i = '0; tbl_dat_i = '0;
    len_i = '0; start_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_cyc", bus.wbm_cyc_o, 0);
    check("rst_adr", bus.wbm_adr_o, 0);
    check("rst_dat", bus.wbm_dat_o, 0);
    check("rst_sel", bus.wbm_sel_o, 0);
    check("rst_state", dbg_state, ST_IDLE);

    write_entry(0, ADDR_FIR, 18'h01234);
    write_entry(1, ADDR_IIR, 18'h3FFFF);
    write_entry(2, ADDR_POLEFIR_BASE, 18'h00001);
    for (int i = 3; i < DEPTH; i++)
      write_entry(i, 7'($urandom_range(0, 127)), 18'($urandom_range(0, 262143)));

    do_burst(3, 8, -1, 0, 0, 0);      // directed three-entry set, 8-cycle target
    do_burst(0, 3, -1, 0, 0, 0);      // update write only
    do_burst(2, 1, -1, 1, 0, 0);      // target never answers
    do_burst(1, 1, -1, 0, 0, 0);      // fastest target, clears err
    do_burst(4, 5, 1, 0, 0, 0);       // bus error on the second write
    do_burst(4, 8, -1, 0, 1, 0);      // start/table write while busy are ignored
    do_burst(4, 2, -1, 0, 0, 0);      // replay shows table untouched
    do_burst(2, 0, -1, 0, 0, 1);      // table write together with start
    do_burst(DEPTH, 0, -1, 0, 0, 0);  // full table

    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(0, DEPTH);
      int ea  = ($urandom_range(0, 4) == 0 && len > 0) ? int'($urandom_range(0, len - 1)) : -1;
      write_entry($urandom_range(0, DEPTH - 1), 7'($urandom_range(0, 127)),
                  18'($urandom_range(0, 262143)));
      do_burst(len, 0, ea, 0, 0, 0);
    end

    // Asynchronous reset in the middle of a write.
    for (int i = 0; i < 5; i++) exp_q.push_back(exp_tbl(i));
    cfg_lat = 8; cfg_err_at = -1; cfg_hang = 0; wr_no = 0;
    @(negedge wb_clk_i);
    first_in_burst = 1;
    start_edge = edge_cnt;
    d0 = done_cnt;
    len_i = 6'd5;
    start_i = 1'b1;
    @(negedge wb_clk_i);
    start_i = 1'b0;
    repeat (5) @(negedge wb_clk_i);
    check("pre_rst_cyc", bus.wbm_cyc_o, 1);
    #2 wb_rst_n_i = 1'b0;
    #1;
    check("arst_cyc", bus.wbm_cyc_o, 0);
    check("arst_stb", bus.wbm_stb_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_err", err_o, 0);
    exp_q.delete();
    repeat (2) @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);
    check("arst_no_done", done_cnt - d0, 0);
    check("arst_state", dbg_state, ST_IDLE);
    do_burst(6, 0, -1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
